trap_controller: RTL and testbench

- Exception sequencer directly upstream of the trap vector lookup.
- Collects exception requests from the IF, ID and MEM pipeline stages and selects the oldest one.
- Latches mepc, mcause and mtval, drives the 4-bit cause into the vector lookup, flushes the pipeline and redirects the PC to the returned handler address.
- Handles mret by redirecting to mepc + RETURN_OFFSET.

---
 rtl/trap_controller.sv | 159 +++++++++++++++
 tb/tb_trap_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Exception sequencer: picks the oldest pending exception, latches the machine
// trap CSRs, flushes the pipeline and redirects fetch to the handler or back on mret.
module trap_controller #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned RETURN_OFFSET = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_misaligned,
    input  logic [XLEN-1:0] if_pc,
    input  logic            id_illegal,
    input  logic            id_ebreak,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_instr,
    input  logic            mem_load_misaligned,
    input  logic [XLEN-1:0] mem_pc,
    input  logic [XLEN-1:0] mem_addr,
    input  logic            mret_req,
    input  logic [XLEN-1:0] handler_address,
    output logic [3:0]      cause,
    output logic            flush_if,
    output logic            flush_id,
    output logic            flush_ex,
    output logic            flush_mem,
    output logic            pc_redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] mepc,
    output logic [3:0]      mcause,
    output logic [XLEN-1:0] mtval,
    output logic            in_trap,
    output logic            double_fault
);

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL          = 4'd1;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd3;
    localparam logic [3:0] CAUSE_DEFAULT          = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT,
        ST_HANDLER,
        ST_RETURN
    } state_t;

    state_t          state, state_next;
    logic            any_exc;
    logic [3:0]      exc_cause;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] exc_tval;
    logic            flush_front_next;
    logic            flush_back_next;
    logic            pc_redirect_next;
    logic [XLEN-1:0] redirect_pc_next;

    assign any_exc = if_misaligned | id_illegal | id_ebreak | mem_load_misaligned;

    // Oldest stage wins; younger requests are discarded because those stages get flushed.
    always_comb begin
        exc_cause = CAUSE_INSTR_MISALIGNED;
        exc_pc    = if_pc;
        exc_tval  = if_pc;
        if (mem_load_misaligned) begin
            exc_cause = CAUSE_LOAD_MISALIGNED;
            exc_pc    = mem_pc;
            exc_tval  = mem_addr;
        end else if (id_illegal) begin
            exc_cause = CAUSE_ILLEGAL;
            exc_pc    = id_pc;
            exc_tval  = id_instr;
        end else if (id_ebreak) begin
            exc_cause = CAUSE_BREAKPOINT;
            exc_pc    = id_pc;
            exc_tval  = '0;
        end
    end

    // Next state plus next values of the registered control outputs.
    always_comb begin
        state_next       = state;
        flush_front_next = 1'b0;
        flush_back_next  = 1'b0;
        pc_redirect_next = 1'b0;
        redirect_pc_next = '0;
        case (state)
            ST_IDLE: begin
                if (any_exc) begin
                    state_next       = ST_FLUSH;
                    flush_front_next = 1'b1;
                    flush_back_next  = 1'b1;
                end
            end
            ST_FLUSH: begin
                // cause has been stable for a cycle, so the lookup result is valid here
                state_next       = ST_REDIRECT;
                flush_front_next = 1'b1;
                pc_redirect_next = 1'b1;
                redirect_pc_next = handler_address;
            end
            ST_REDIRECT: begin
                state_next = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (mret_req) begin
                    state_next       = ST_RETURN;
                    flush_front_next = 1'b1;
                    pc_redirect_next = 1'b1;
                    redirect_pc_next = mepc + XLEN'(RETURN_OFFSET);
                end
            end
            ST_RETURN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cause        <= CAUSE_DEFAULT;
            mcause       <= '0;
            mepc         <= '0;
            mtval        <= '0;
            flush_if     <= 1'b0;
            flush_id     <= 1'b0;
            flush_ex     <= 1'b0;
            flush_mem    <= 1'b0;
            pc_redirect  <= 1'b0;
            redirect_pc  <= '0;
            in_trap      <= 1'b0;
            double_fault <= 1'b0;
        end else begin
            state       <= state_next;
            flush_if    <= flush_front_next;
            flush_id    <= flush_front_next;
            flush_ex    <= flush_back_next;
            flush_mem   <= flush_back_next;
            pc_redirect <= pc_redirect_next;
            redirect_pc <= redirect_pc_next;
            in_trap     <= (state_next != ST_IDLE);
            if (state == ST_IDLE && any_exc) begin
                cause  <= exc_cause;
                mcause <= exc_cause;
                mepc   <= exc_pc;
                mtval  <= exc_tval;
            end
            // Nested exceptions are only recorded, never serviced
            if (state == ST_HANDLER && any_exc) begin
                double_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: expected redirects are queued by the
// stimulus and checked by a monitor whenever pc_redirect is presented.
module tb_trap_controller;

    logic        clk;
    logic        rst_n;
    logic        if_misaligned;
    logic [31:0] if_pc;
    logic        id_illegal;
    logic        id_ebreak;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        mem_load_misaligned;
    logic [31:0] mem_pc;
    logic [31:0] mem_addr;
    logic        mret_req;
    logic [31:0] handler_address;
    logic [3:0]  cause;
    logic        flush_if, flush_id, flush_ex, flush_mem;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mepc;
    logic [3:0]  mcause;
    logic [31:0] mtval;
    logic        in_trap;
    logic        double_fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] mepc;
        logic [3:0]  mcause;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    trap_controller #(.XLEN(32), .RETURN_OFFSET(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .if_misaligned      (if_misaligned),
        .if_pc              (if_pc),
        .id_illegal         (id_illegal),
        .id_ebreak          (id_ebreak),
        .id_pc              (id_pc),
        .id_instr           (id_instr),
        .mem_load_misaligned(mem_load_misaligned),
        .mem_pc             (mem_pc),
        .mem_addr           (mem_addr),
        .mret_req           (mret_req),
        .handler_address    (handler_address),
        .cause              (cause),
        .flush_if           (flush_if),
        .flush_id           (flush_id),
        .flush_ex           (flush_ex),
        .flush_mem          (flush_mem),
        .pc_redirect        (pc_redirect),
        .redirect_pc        (redirect_pc),
        .mepc               (mepc),
        .mcause             (mcause),
        .mtval              (mtval),
        .in_trap            (in_trap),
        .double_fault       (double_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector lookup model: 0x80 + 4*cause, default vector 0 for cause 0xF
    assign handler_address = (cause == 4'hF) ? 32'h0 : 32'h80 + {26'd0, cause, 2'b00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every redirect the DUT presents must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && pc_redirect) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_redirect", 32'(pc_redirect), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("redirect_pc", redirect_pc, e.pc);
                chk("redirect_mepc", mepc, e.mepc);
                chk("redirect_mcause", 32'(mcause), 32'(e.mcause));
                chk("redirect_flush_front", {30'd0, flush_if, flush_id}, 32'h3);
                chk("redirect_flush_back", {30'd0, flush_ex, flush_mem}, 32'h0);
                chk("redirect_in_trap", 32'(in_trap), 32'd1);
            end
        end
    end

    task automatic clear_exc();
        if_misaligned       = 1'b0;
        id_illegal          = 1'b0;
        id_ebreak           = 1'b0;
        mem_load_misaligned = 1'b0;
    endtask

    // Raise an exception set for one edge (two when hold=1, second lands in FLUSH and is ignored).
    task automatic do_trap(input logic ifm, input logic [31:0] ifpc, input logic ill, input logic eb,
                           input logic [31:0] idpc, input logic [31:0] instr, input logic lm,
                           input logic [31:0] mpc, input logic [31:0] maddr,
                           input logic [3:0] ecause, input logic [31:0] emepc,
                           input logic [31:0] emtval, input logic hold);
        exp_t e;
        @(negedge clk);
        e.pc = 32'h80 + {26'd0, ecause, 2'b00};
        e.mepc = emepc;
        e.mcause = ecause;
        exp_q.push_back(e);
        if_misaligned = ifm; if_pc = ifpc;
        id_illegal = ill; id_ebreak = eb; id_pc = idpc; id_instr = instr;
        mem_load_misaligned = lm; mem_pc = mpc; mem_addr = maddr;
        @(negedge clk);
        if (!hold) clear_exc();
        chk("flush_cause", 32'(cause), 32'(ecause));
        chk("flush_all", {28'd0, flush_if, flush_id, flush_ex, flush_mem}, 32'hF);
        chk("flush_in_trap", 32'(in_trap), 32'd1);
        chk("flush_no_redirect", 32'(pc_redirect), 32'd0);
        chk("mcause", 32'(mcause), 32'(ecause));
        chk("mepc", mepc, emepc);
        chk("mtval", mtval, emtval);
        @(negedge clk);
        clear_exc();
        @(negedge clk);
        chk("handler_quiet", {27'd0, flush_if, flush_id, flush_ex, flush_mem, pc_redirect}, 32'd0);
        chk("handler_in_trap", 32'(in_trap), 32'd1);
    endtask

    task automatic do_return(input logic [31:0] emepc, input logic [3:0] ecause,
                             input logic exc_too, input logic exp_df);
        exp_t e;
        @(negedge clk);
        e.pc = emepc + 32'd4;
        e.mepc = emepc;
        e.mcause = ecause;
        exp_q.push_back(e);
        mret_req = 1'b1;
        id_illegal = exc_too;
        @(negedge clk);
        mret_req = 1'b0;
        clear_exc();
        @(negedge clk);
        chk("post_return_in_trap", 32'(in_trap), 32'd0);
        chk("post_return_quiet", {27'd0, flush_if, flush_id, flush_ex, flush_mem, pc_redirect}, 32'd0);
        chk("post_return_double_fault", 32'(double_fault), 32'(exp_df));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cause"}, 32'(cause), 32'hF);
        chk({tag, "_csrs"}, mepc | mtval | 32'(mcause), 32'd0);
        chk({tag, "_ctrl"}, {25'd0, flush_if, flush_id, flush_ex, flush_mem, pc_redirect, in_trap, double_fault}, 32'd0);
        chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        mret_req = 1'b0;
        if_pc = '0; id_pc = '0; id_instr = '0; mem_pc = '0; mem_addr = '0;
        clear_exc();
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;

        // Illegal instruction, with inputs held into FLUSH (must not double-fault)
        do_trap(0, 32'h0, 1, 0, 32'h100, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 4'd1, 32'h100, 32'hFFFF_FFFF, 1);
        chk("flush_ignored_df", 32'(double_fault), 32'd0);
        do_return(32'h100, 4'd1, 0, 0);

        // MEM beats IF in the same cycle
        do_trap(1, 32'h20A, 0, 0, 32'h0, 32'h0, 1, 32'h200, 32'h1003, 4'd3, 32'h200, 32'h1003, 0);
        do_return(32'h200, 4'd3, 0, 0);

        // Illegal beats ebreak
        do_trap(0, 32'h0, 1, 1, 32'h300, 32'h1234_5678, 0, 32'h0, 32'h0, 4'd1, 32'h300, 32'h1234_5678, 0);
        do_return(32'h300, 4'd1, 0, 0);

        // ebreak alone: mtval is zero
        do_trap(0, 32'h0, 0, 1, 32'h40, 32'hDEAD_BEEF, 0, 32'h0, 32'h0, 4'd2, 32'h40, 32'h0, 0);
        do_return(32'h40, 4'd2, 0, 0);

        // mret in IDLE is ignored
        @(negedge clk);
        mret_req = 1'b1;
        @(negedge clk);
        mret_req = 1'b0;
        chk("idle_mret_in_trap", 32'(in_trap), 32'd0);
        chk("idle_mret_redirect", 32'(pc_redirect), 32'd0);

        // IF misaligned, then a nested exception in HANDLER
        do_trap(1, 32'h20A, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 4'd0, 32'h20A, 32'h20A, 0);
        @(negedge clk);
        if_misaligned = 1'b1; if_pc = 32'h999;
        @(negedge clk);
        clear_exc();
        chk("nested_double_fault", 32'(double_fault), 32'd1);
        chk("nested_mepc", mepc, 32'h20A);
        chk("nested_mtval", mtval, 32'h20A);
        chk("nested_in_trap", 32'(in_trap), 32'd1);
        chk("nested_no_redirect", 32'(pc_redirect), 32'd0);
        do_return(32'h20A, 4'd0, 0, 1);

        // Reset asserted during the REDIRECT cycle
        begin
            exp_t e;
            @(negedge clk);
            e.pc = 32'h84; e.mepc = 32'h500; e.mcause = 4'd1;
            exp_q.push_back(e);
            id_illegal = 1'b1; id_pc = 32'h500; id_instr = 32'h0000_0013;
            @(negedge clk);
            clear_exc();
            @(negedge clk);
            chk("pre_reset_redirect", 32'(pc_redirect), 32'd1);
            #2 rst_n = 1'b0;
            #1 chk_reset_state("midtrap_reset");
            @(negedge clk);
            rst_n = 1'b1;
        end

        // Serviced normally after reset; mret and an exception together still set double_fault
        do_trap(0, 32'h0, 0, 1, 32'h600, 32'h0, 0, 32'h0, 32'h0, 4'd2, 32'h600, 32'h0, 0);
        chk("post_reset_df", 32'(double_fault), 32'd0);
        do_return(32'h600, 4'd2, 1, 1);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
